// File: rtl/partition_pkg.sv
// Shared types and width helpers for the partition sweep controller.
package partition_pkg;

   localparam int unsigned DEF_IN_W  = 8;
   localparam int unsigned DEF_OUT_W = 5;

   // Hamming-sum width: 2^in_w vectors, each contributing at most out_w bits.
   function automatic int unsigned hs_width(input int unsigned in_w, input int unsigned out_w);
      return in_w + $clog2(out_w + 1);
   endfunction

   localparam int unsigned DEF_HS_W = hs_width(DEF_IN_W, DEF_OUT_W);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_DRIVE  = 3'd1,
      ST_SAMPLE = 3'd2,
      ST_EMIT   = 3'd3,
      ST_DONE   = 3'd4
   } sweep_state_e;

endpackage

// File: rtl/partition_err_metric.sv
// Combinational error metrics between exact and approximate partition outputs.
module partition_err_metric
   import partition_pkg::*;
#(
   parameter int unsigned OUT_W = DEF_OUT_W,
   parameter int unsigned PC_W  = $clog2(OUT_W + 1)
) (
   input  logic [OUT_W-1:0] po_exact,
   input  logic [OUT_W-1:0] po_approx,
   output logic             mismatch_c,
   output logic [PC_W-1:0]  popcnt_c,
   output logic [OUT_W-1:0] abs_diff_c
);

   logic [OUT_W-1:0] diff_bits;

   assign diff_bits = po_exact ^ po_approx;

   always_comb begin
      popcnt_c = '0;
      for (int i = 0; i < int'(OUT_W); i++) begin
         popcnt_c = popcnt_c + PC_W'(diff_bits[i]);
      end
      mismatch_c = |diff_bits;
      abs_diff_c = (po_exact >= po_approx) ? (po_exact - po_approx) : (po_approx - po_exact);
   end

endmodule

// File: rtl/partition_sweep_ctrl.sv
// Exhaustive sweep of a partition input space, comparing exact vs approximate
// outputs vector by vector and streaming per-vector records plus running totals.
module partition_sweep_ctrl
   import partition_pkg::*;
#(
   parameter int unsigned  IN_W  = DEF_IN_W,
   parameter int unsigned  OUT_W = DEF_OUT_W,
   localparam int unsigned HS_W  = hs_width(IN_W, OUT_W)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   output logic [IN_W-1:0]  pi,
   input  logic [OUT_W-1:0] po_exact,
   input  logic [OUT_W-1:0] po_approx,
   output logic             rec_valid,
   input  logic             rec_ready,
   output logic [IN_W-1:0]  rec_pi,
   output logic [OUT_W-1:0] rec_po,
   output logic             rec_err,
   output logic             busy,
   output logic             done,
   output logic [IN_W:0]    err_count,
   output logic [HS_W-1:0]  ham_sum,
   output logic [OUT_W-1:0] max_abs_err
);

   localparam int unsigned PC_W = $clog2(OUT_W + 1);

   sweep_state_e     state_q;
   sweep_state_e     state_d;
   logic             busy_d;
   logic             done_d;
   logic             valid_d;
   logic             last_c;
   logic             sweep_go_c;
   logic             sample_c;
   logic             advance_c;
   logic             mismatch_c;
   logic [PC_W-1:0]  popcnt_c;
   logic [OUT_W-1:0] abs_diff_c;

   partition_err_metric #(
      .OUT_W (OUT_W),
      .PC_W  (PC_W)
   ) u_err_metric (
      .po_exact   (po_exact),
      .po_approx  (po_approx),
      .mismatch_c (mismatch_c),
      .popcnt_c   (popcnt_c),
      .abs_diff_c (abs_diff_c)
   );

   assign last_c = (pi == {IN_W{1'b1}});

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: abort outranks start and the record handshake
   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE,
            ST_DONE:   if (start) state_d = ST_DRIVE;
            ST_DRIVE:  state_d = ST_SAMPLE;
            ST_SAMPLE: state_d = ST_EMIT;
            ST_EMIT:   if (rec_ready) state_d = last_c ? ST_DONE : ST_DRIVE;
            default:   state_d = ST_IDLE;
         endcase
      end
   end

   // Output decode, registered alongside the state
   always_comb begin
      busy_d     = 1'b0;
      done_d     = 1'b0;
      valid_d    = 1'b0;
      sweep_go_c = 1'b0;
      sample_c   = 1'b0;
      advance_c  = 1'b0;
      case (state_d)
         ST_DRIVE,
         ST_SAMPLE: busy_d = 1'b1;
         ST_EMIT:   begin busy_d = 1'b1; valid_d = 1'b1; end
         ST_DONE:   done_d = 1'b1;
         default:   ;
      endcase
      if ((state_q == ST_IDLE || state_q == ST_DONE) && state_d == ST_DRIVE) sweep_go_c = 1'b1;
      if (state_q == ST_SAMPLE && state_d == ST_EMIT)                        sample_c   = 1'b1;
      if (state_q == ST_EMIT && state_d == ST_DRIVE)                         advance_c  = 1'b1;
   end

   // Vector counter, record capture and accumulators
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pi          <= '0;
         rec_valid   <= 1'b0;
         rec_pi      <= '0;
         rec_po      <= '0;
         rec_err     <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         err_count   <= '0;
         ham_sum     <= '0;
         max_abs_err <= '0;
      end else begin
         rec_valid <= valid_d;
         busy      <= busy_d;
         done      <= done_d;
         if (sweep_go_c) begin
            pi          <= '0;
            rec_pi      <= '0;
            rec_po      <= '0;
            rec_err     <= 1'b0;
            err_count   <= '0;
            ham_sum     <= '0;
            max_abs_err <= '0;
         end else if (sample_c) begin
            rec_pi    <= pi;
            rec_po    <= po_approx;
            rec_err   <= mismatch_c;
            err_count <= err_count + (IN_W+1)'(mismatch_c);
            ham_sum   <= ham_sum + HS_W'(popcnt_c);
            if (abs_diff_c > max_abs_err) max_abs_err <= abs_diff_c;
         end else if (advance_c) begin
            pi <= pi + IN_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_partition_sweep_ctrl.sv
// Randomized bench for partition_sweep_ctrl against a table-driven reference model.
module tb_partition_sweep_ctrl;

   localparam int unsigned IN_W  = 8;
   localparam int unsigned OUT_W = 5;
   localparam int unsigned HS_W  = 11;
   localparam int          N_VEC = 256;
   localparam int          LIMIT = 4000;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic             abort = 1'b0;
   logic             rec_ready = 1'b1;
   logic [IN_W-1:0]  pi;
   logic [OUT_W-1:0] po_exact;
   logic [OUT_W-1:0] po_approx;
   logic             rec_valid;
   logic [IN_W-1:0]  rec_pi;
   logic [OUT_W-1:0] rec_po;
   logic             rec_err;
   logic             busy;
   logic             done;
   logic [IN_W:0]    err_count;
   logic [HS_W-1:0]  ham_sum;
   logic [OUT_W-1:0] max_abs_err;

   logic [OUT_W-1:0] ex_tbl [N_VEC];
   logic [OUT_W-1:0] ap_tbl [N_VEC];

   int checks    = 0;
   int failures  = 0;
   int exp_idx   = 0;
   int ready_mode = 0;
   int stall_cnt = 0;

   always #5 clk = ~clk;

   // The partition instances live outside the DUT: model them as lookup tables.
   assign po_exact  = ex_tbl[pi];
   assign po_approx = ap_tbl[pi];

   partition_sweep_ctrl #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .abort       (abort),
      .pi          (pi),
      .po_exact    (po_exact),
      .po_approx   (po_approx),
      .rec_valid   (rec_valid),
      .rec_ready   (rec_ready),
      .rec_pi      (rec_pi),
      .rec_po      (rec_po),
      .rec_err     (rec_err),
      .busy        (busy),
      .done        (done),
      .err_count   (err_count),
      .ham_sum     (ham_sum),
      .max_abs_err (max_abs_err)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // 0: identity, 1: approx tied to zero, 2: random with partial agreement
   task automatic fill_tables(input int mode);
      for (int v = 0; v < N_VEC; v++) begin
         case (mode)
            0: begin ex_tbl[v] = OUT_W'(v); ap_tbl[v] = OUT_W'(v); end
            1: begin ex_tbl[v] = OUT_W'(v); ap_tbl[v] = '0; end
            default: begin
               ex_tbl[v] = OUT_W'($urandom);
               ap_tbl[v] = ($urandom_range(0, 2) == 0) ? OUT_W'($urandom) : ex_tbl[v];
            end
         endcase
      end
   endtask

   // Reference totals over vectors 0..last, straight from the metric definitions
   task automatic model_totals(input int last, output int ec, output int hs, output int mx);
      int a, b, d;
      ec = 0; hs = 0; mx = 0;
      for (int v = 0; v <= last; v++) begin
         a = int'(ex_tbl[v]);
         b = int'(ap_tbl[v]);
         d = (a > b) ? a - b : b - a;
         if (a != b) ec++;
         hs += $countones(ex_tbl[v] ^ ap_tbl[v]);
         if (d > mx) mx = d;
      end
   endtask

   task automatic check_totals(input string tag, input int last);
      int ec, hs, mx;
      model_totals(last, ec, hs, mx);
      check({tag, "_err_count"}, 64'(err_count), 64'(ec));
      check({tag, "_ham_sum"}, 64'(ham_sum), 64'(hs));
      check({tag, "_max_abs_err"}, 64'(max_abs_err), 64'(mx));
   endtask

   task automatic start_sweep();
      @(negedge clk);
      exp_idx = 0;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Edges after the start edge until done is observed
   task automatic wait_done(output int n);
      n = 0;
      while (!done && n < LIMIT) begin
         @(posedge clk);
         #1 n++;
      end
      if (n >= LIMIT) check("done_timeout", 64'(n), 64'(0));
   endtask

   task automatic wait_emit_of(input int v, output bit ok);
      int n;
      n = 0;
      ok = 1'b0;
      while (n < LIMIT && !ok) begin
         @(posedge clk);
         #1 n++;
         if (rec_valid && int'(rec_pi) == v) ok = 1'b1;
      end
      if (!ok) check("emit_timeout", 64'(n), 64'(0));
   endtask

   // Consumer: ready pattern chosen per test
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         1: rec_ready = 1'($urandom_range(0, 1));
         2: begin
            if (rec_valid && rec_pi == 8'd5 && stall_cnt < 10) begin
               rec_ready = 1'b0;
               stall_cnt++;
            end else begin
               rec_ready = 1'b1;
            end
         end
         default: rec_ready = 1'b1;
      endcase
   end

   // Record monitor: every accepted record must be the next vector in order
   always @(negedge clk) begin
      if (rst_n && rec_valid && rec_ready) begin
         if (exp_idx < N_VEC) begin
            check("rec_pi", 64'(rec_pi), 64'(exp_idx));
            check("rec_po", 64'(rec_po), 64'(ap_tbl[exp_idx]));
            check("rec_err", 64'(rec_err), 64'(ex_tbl[exp_idx] != ap_tbl[exp_idx]));
         end else begin
            check("rec_overrun", 64'(exp_idx), 64'(N_VEC - 1));
         end
         exp_idx++;
      end
   end

   initial begin
      int n;
      bit ok;

      fill_tables(0);
      #12;
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      check("rst_valid", 64'(rec_valid), 64'(0));
      check("rst_pi", 64'(pi), 64'(0));
      check("rst_err_count", 64'(err_count), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check("idle_no_activity", 64'({busy, done, rec_valid}), 64'(0));

      // Identity partitions: no errors, exact sweep length
      ready_mode = 0;
      start_sweep();
      check("sweep_busy", 64'(busy), 64'(1));
      wait_done(n);
      check("done_edge_identity", 64'(n), 64'(768));
      check("records_identity", 64'(exp_idx), 64'(N_VEC));
      check_totals("identity", N_VEC - 1);
      check("identity_err_const", 64'(err_count), 64'(0));

      // Approx tied low, with a start pulse mid-sweep that must be ignored
      fill_tables(1);
      start_sweep();
      n = 0;
      while (!done && n < LIMIT) begin
         @(posedge clk);
         #1 n++;
         start = (n == 300);
      end
      start = 1'b0;
      check("done_edge_busy_start", 64'(n), 64'(768));
      check("records_zero", 64'(exp_idx), 64'(N_VEC));
      check("zero_err_count", 64'(err_count), 64'(248));
      check("zero_ham_sum", 64'(ham_sum), 64'(640));
      check("zero_max_abs", 64'(max_abs_err), 64'(31));
      repeat (3) @(negedge clk);
      check("done_held", 64'(done), 64'(1));
      check("totals_held", 64'(err_count), 64'(248));

      // Back-pressure at vector 5
      ready_mode = 2;
      stall_cnt = 0;
      start_sweep();
      n = 0;
      while (stall_cnt < 1 && n < LIMIT) begin
         @(negedge clk);
         n++;
      end
      for (int k = 0; k < 10; k++) begin
         check("stall_valid", 64'(rec_valid), 64'(1));
         check("stall_rec_pi", 64'(rec_pi), 64'(5));
         check("stall_rec_po", 64'(rec_po), 64'(ap_tbl[5]));
         check("stall_pi", 64'(pi), 64'(5));
         @(negedge clk);
      end
      wait_done(n);
      check("records_stall", 64'(exp_idx), 64'(N_VEC));
      check_totals("stall", N_VEC - 1);

      // Random partitions, random back-pressure, two sweeps
      ready_mode = 1;
      for (int s = 0; s < 2; s++) begin
         fill_tables(2);
         start_sweep();
         wait_done(n);
         check("records_random", 64'(exp_idx), 64'(N_VEC));
         check_totals("random", N_VEC - 1);
      end

      // Abort while vector 100 is being emitted
      ready_mode = 0;
      fill_tables(2);
      start_sweep();
      wait_emit_of(100, ok);
      abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      check("abort_valid", 64'(rec_valid), 64'(0));
      check("abort_busy", 64'(busy), 64'(0));
      check("abort_done", 64'(done), 64'(0));
      check_totals("abort", 100);
      repeat (4) @(negedge clk);
      check("abort_idle_quiet", 64'({busy, rec_valid}), 64'(0));

      // Reset while vector 50 is in SAMPLE, then a clean sweep from zero
      ready_mode = 0;
      fill_tables(2);
      start_sweep();
      wait_emit_of(49, ok);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_zero", 64'({pi, rec_pi, rec_po, rec_err, rec_valid, busy, done}), 64'(0));
      check("mid_rst_acc", 64'({err_count, ham_sum, max_abs_err}), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check("post_rst_quiet", 64'({busy, done, pi}), 64'(0));
      ready_mode = 1;
      start_sweep();
      wait_done(n);
      check("records_after_rst", 64'(exp_idx), 64'(N_VEC));
      check_totals("after_rst", N_VEC - 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
